// File: rtl/trap_ctrl.sv
// M-mode trap controller: priority-selects exceptions/interrupts, drains the pipeline, commits trap CSRs and redirects fetch.
// Optional TRAP_CTRL_VECTORED_EN enables vectored interrupt dispatch when mtvec[1:0] == 2'b01.
module trap_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              NUM_EXC   = 16,
  parameter int              NUM_IRQ   = 12,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXC-1:0] exc_req,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [NUM_IRQ-1:0] irq_pend,
  input  logic               mret,
  input  logic               flush_ack,
  input  logic               csr_we,
  input  logic [1:0]         csr_sel,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               flush_req,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mtval,
  output logic               trap_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    REDIR  = 2'd2,
    RET    = 2'd3
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0]    mtvec;
  logic [NUM_IRQ-1:0] mie;
  logic               mstat_mie;
  logic               mstat_mpie;

  // Event latched in IDLE, held through DRAIN until commit.
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] cause_p0;
  logic [XLEN-1:0] tval_p0;

  logic exc_any, irq_take, event_take, commit, ret_take;
  logic [XLEN-1:0] trap_base;

  function automatic logic [XLEN-2:0] exc_index(input logic [NUM_EXC-1:0] req);
    logic [XLEN-2:0] idx;
    idx = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (req[i]) idx = (XLEN-1)'(i);
    end
    return idx;
  endfunction

  function automatic logic [XLEN-2:0] irq_index(input logic [NUM_IRQ-1:0] req);
    logic [XLEN-2:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = (XLEN-1)'(i);
    end
    return idx;
  endfunction

  function automatic logic [XLEN-1:0] mtvec_mask(input logic [XLEN-1:0] val);
`ifdef TRAP_CTRL_VECTORED_EN
    return val;
`else
    return {val[XLEN-1:2], 2'b00};
`endif
  endfunction

  assign exc_any    = |exc_req;
  assign irq_take   = mstat_mie & (|(irq_pend & mie));
  assign event_take = (state == IDLE) && (exc_any || irq_take);
  assign ret_take   = (state == IDLE) && !(exc_any || irq_take) && mret;
  assign commit     = (state == DRAIN) && flush_ack;

  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (exc_any || irq_take) state_n = DRAIN;
        else if (mret)           state_n = RET;
      end
      DRAIN:   if (flush_ack) state_n = REDIR;
      REDIR:   state_n = IDLE;
      RET:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    flush_req      = (state == DRAIN);
    redirect_valid = (state == REDIR) || (state == RET);
    trap_busy      = (state != IDLE);
    redirect_pc    = '0;
    if (state == RET) begin
      redirect_pc = mepc;
    end else if (state == REDIR) begin
      redirect_pc = trap_base;
`ifdef TRAP_CTRL_VECTORED_EN
      if (mtvec[1:0] == 2'b01 && mcause[XLEN-1])
        redirect_pc = trap_base + {mcause[XLEN-3:0], 2'b00};
`endif
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_sel)
      2'd0: csr_rdata = mtvec;
      2'd1: csr_rdata = XLEN'(mie);
      2'd2: begin
        csr_rdata[3] = mstat_mie;
        csr_rdata[7] = mstat_mpie;
      end
      default: csr_rdata = mepc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mtvec      <= mtvec_mask(RESET_VEC);
      mie        <= '0;
      mstat_mie  <= 1'b0;
      mstat_mpie <= 1'b0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else begin
      state <= state_n;
      if (csr_we) begin
        case (csr_sel)
          2'd0:    mtvec     <= mtvec_mask(csr_wdata);
          2'd1:    mie       <= csr_wdata[NUM_IRQ-1:0];
          2'd2:    mstat_mie <= csr_wdata[3];
          default: mepc      <= {csr_wdata[XLEN-1:2], 2'b00};
        endcase
      end
      // Trap commit and MRET come last so they win over a same-cycle CSR write.
      if (commit) begin
        mepc       <= pc_p0;
        mcause     <= cause_p0;
        mtval      <= tval_p0;
        mstat_mpie <= mstat_mie;
        mstat_mie  <= 1'b0;
      end
      if (ret_take) begin
        mstat_mie  <= mstat_mpie;
        mstat_mpie <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (event_take) begin
      pc_p0 <= exc_pc;
      if (exc_any) begin
        cause_p0 <= {1'b0, exc_index(exc_req)};
        tval_p0  <= exc_tval;
      end else begin
        cause_p0 <= {1'b1, irq_index(irq_pend & mie)};
        tval_p0  <= '0;
      end
    end
  end

endmodule
